// File: rtl/dac_pkg.sv
// Shared types and constants for the serial DAC driver.
package dac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        HOLD,
        LDAC
    } dac_state_t;

    localparam int         FRAME_BITS  = 16;
    localparam logic [3:0] DEFAULT_CMD = 4'b0011;

endpackage

// File: rtl/rate_tick_gen.sv
// Free-running divider: one-cycle tick every DIV sys_clk cycles, first tick in cycle DIV-1.
module rate_tick_gen #(
    parameter int DIV = 100
) (
    input  logic sys_clk,
    input  logic rst_n,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/dac_spi_driver.sv
// Samples the DDS word at a fixed rate and ships it as a 16-bit SPI frame followed by an LDAC strobe.
module dac_spi_driver
    import dac_pkg::*;
#(
    parameter int         CLK_DIV    = 2,
    parameter int         SAMPLE_DIV = 100,
    parameter logic [3:0] CMD        = DEFAULT_CMD,
    parameter int         LDAC_W     = 2
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic [11:0] din,
    output logic        dac_cs_n,
    output logic        dac_sclk,
    output logic        dac_sdi,
    output logic        dac_ldac_n,
    output logic        busy,
    output logic        sample_taken,
    output logic        overrun
);

    localparam int            HW        = $clog2(CLK_DIV) + 1;
    localparam int            LW        = $clog2(LDAC_W) + 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
    localparam logic [LW-1:0] LDAC_LAST = LW'(LDAC_W - 1);
    localparam logic [4:0]    LAST_BIT  = 5'(FRAME_BITS - 1);

    dac_state_t            state_reg, state_next;
    logic [FRAME_BITS-1:0] shreg_reg, shreg_next;
    logic [4:0]            bit_cnt_reg, bit_cnt_next;
    logic [HW-1:0]         half_cnt_reg, half_cnt_next;
    logic [LW-1:0]         ldac_cnt_reg, ldac_cnt_next;
    logic                  cs_n_reg, cs_n_next;
    logic                  sclk_reg, sclk_next;
    logic                  sdi_reg, sdi_next;
    logic                  ldac_n_reg, ldac_n_next;
    logic                  busy_reg;
    logic                  overrun_reg;
    logic                  tick;

    rate_tick_gen #(
        .DIV(SAMPLE_DIV)
    ) u_tick (
        .sys_clk(sys_clk),
        .rst_n  (rst_n),
        .tick   (tick)
    );

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            shreg_reg    <= '0;
            bit_cnt_reg  <= '0;
            half_cnt_reg <= '0;
            ldac_cnt_reg <= '0;
            cs_n_reg     <= 1'b1;
            sclk_reg     <= 1'b0;
            sdi_reg      <= 1'b0;
            ldac_n_reg   <= 1'b1;
            busy_reg     <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shreg_reg    <= shreg_next;
            bit_cnt_reg  <= bit_cnt_next;
            half_cnt_reg <= half_cnt_next;
            ldac_cnt_reg <= ldac_cnt_next;
            cs_n_reg     <= cs_n_next;
            sclk_reg     <= sclk_next;
            sdi_reg      <= sdi_next;
            ldac_n_reg   <= ldac_n_next;
            busy_reg     <= (state_next != IDLE);
            overrun_reg  <= overrun_reg | (tick && (state_reg != IDLE));
        end
    end

    // Output registers are loaded with the values belonging to the next state,
    // so every pin changes exactly on the state transition edge.
    always_comb begin
        state_next    = state_reg;
        shreg_next    = shreg_reg;
        bit_cnt_next  = bit_cnt_reg;
        half_cnt_next = half_cnt_reg;
        ldac_cnt_next = ldac_cnt_reg;
        cs_n_next     = cs_n_reg;
        sclk_next     = sclk_reg;
        sdi_next      = sdi_reg;
        ldac_n_next   = ldac_n_reg;
        case (state_reg)
            IDLE: begin
                if (tick) begin
                    state_next = LOAD;
                    shreg_next = {CMD, din};
                    cs_n_next  = 1'b0;
                    sclk_next  = 1'b0;
                    sdi_next   = CMD[3];
                end
            end
            LOAD: begin
                state_next    = SHIFT;
                bit_cnt_next  = '0;
                half_cnt_next = '0;
                sdi_next      = shreg_reg[FRAME_BITS-1];
            end
            SHIFT: begin
                if (half_cnt_reg == HALF_LAST) begin
                    half_cnt_next = '0;
                    if (!sclk_reg) begin
                        sclk_next = 1'b1;
                    end else begin
                        // falling edge: advance to the next bit while sclk is low
                        sclk_next    = 1'b0;
                        shreg_next   = {shreg_reg[FRAME_BITS-2:0], 1'b0};
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                        if (bit_cnt_reg == LAST_BIT) begin
                            state_next = HOLD;
                            cs_n_next  = 1'b1;
                            sdi_next   = 1'b0;
                        end else begin
                            sdi_next = shreg_reg[FRAME_BITS-2];
                        end
                    end
                end else begin
                    half_cnt_next = half_cnt_reg + 1'b1;
                end
            end
            HOLD: begin
                state_next    = LDAC;
                ldac_n_next   = 1'b0;
                ldac_cnt_next = '0;
            end
            LDAC: begin
                if (ldac_cnt_reg == LDAC_LAST) begin
                    state_next  = IDLE;
                    ldac_n_next = 1'b1;
                end else begin
                    ldac_cnt_next = ldac_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign dac_cs_n     = cs_n_reg;
    assign dac_sclk     = sclk_reg;
    assign dac_sdi      = sdi_reg;
    assign dac_ldac_n   = ldac_n_reg;
    assign busy         = busy_reg;
    assign overrun      = overrun_reg;
    assign sample_taken = tick && (state_reg == IDLE);

endmodule

// File: tb/tb_dac_spi_driver.sv
// Bench for dac_spi_driver: cycle-level waveform model plus an SPI frame decoder.
module tb_dac_spi_driver;

    localparam int         CD   = 2;
    localparam int         LW   = 2;
    localparam int         SH   = 32 * CD;
    localparam int         FCYC = 2 + SH + LW;
    localparam logic [3:0] CMDV = 4'b0011;

    logic        sys_clk = 1'b0;
    logic        rst0 = 1'b0;
    logic        rst1 = 1'b0;
    logic        sel = 1'b0;
    logic [11:0] din = 12'h000;

    logic cs0, sclk0, sdi0, ld0, busy0, st0, ov0;
    logic cs1, sclk1, sdi1, ld1, busy1, st1, ov1;

    always #5 sys_clk = ~sys_clk;

    dac_spi_driver dut0 (
        .sys_clk(sys_clk), .rst_n(rst0), .din(din),
        .dac_cs_n(cs0), .dac_sclk(sclk0), .dac_sdi(sdi0), .dac_ldac_n(ld0),
        .busy(busy0), .sample_taken(st0), .overrun(ov0)
    );

    dac_spi_driver #(.SAMPLE_DIV(40)) dut1 (
        .sys_clk(sys_clk), .rst_n(rst1), .din(din),
        .dac_cs_n(cs1), .dac_sclk(sclk1), .dac_sdi(sdi1), .dac_ldac_n(ld1),
        .busy(busy1), .sample_taken(st1), .overrun(ov1)
    );

    wire cs_s   = sel ? cs1   : cs0;
    wire sclk_s = sel ? sclk1 : sclk0;
    wire sdi_s  = sel ? sdi1  : sdi0;
    wire ld_s   = sel ? ld1   : ld0;
    wire busy_s = sel ? busy1 : busy0;
    wire st_s   = sel ? st1   : st0;
    wire ov_s   = sel ? ov1   : ov0;
    wire rst_s  = sel ? rst1  : rst0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Reference model: frame timeline derived from the tick schedule and frame length.
    int          m_cyc   = 0;
    int          m_start = -1000;
    logic        m_ovr   = 1'b0;
    logic [15:0] m_frame = 16'h0;
    bit          m_took  = 1'b0;
    logic [15:0] exp_q[$];

    always @(negedge sys_clk) begin
        logic [6:0] act_v, exp_v;
        int  div, c, k;
        bit  bsy, tck, stt, cs, sck, sd, ld;
        act_v = {cs_s, sclk_s, sdi_s, ld_s, busy_s, st_s, ov_s};
        if (!rst_s) begin
            exp_v   = 7'b1001000;
            m_cyc   = 0;
            m_start = -1000;
            m_ovr   = 1'b0;
            exp_q.delete();
        end else begin
            div = sel ? 40 : 100;
            c   = m_cyc;
            k   = c - m_start;
            bsy = (m_start >= 0) && (k >= 1) && (k <= FCYC);
            tck = (c % div) == div - 1;
            stt = tck && !bsy;
            cs  = !(bsy && k <= 1 + SH);
            sck = bsy && k >= 2 && k <= 1 + SH && (((k - 2) / CD) % 2 == 1);
            sd  = 1'b0;
            if (bsy && k == 1) sd = m_frame[15];
            else if (bsy && k >= 2 && k <= 1 + SH) sd = m_frame[15 - (k - 2) / (2 * CD)];
            ld  = !(bsy && k >= 3 + SH);
            exp_v = {cs, sck, sd, ld, bsy, stt, m_ovr};
            if (tck && bsy) m_ovr = 1'b1;
            if (stt) begin
                m_start = c;
                m_frame = {CMDV, din};
                exp_q.push_back(m_frame);
                m_took = 1'b1;
            end
            m_cyc++;
        end
        check_eq($sformatf("outs@%0d", m_cyc), 32'(act_v), 32'(exp_v));
    end

    // Frame decoder: shifts sdi on each sclk rising edge while cs_n is low.
    int          dec_edges  = 0;
    int          dec_frames = 0;
    logic [15:0] dec_word   = 16'h0;
    bit          inc_mode   = 1'b0;
    bit          have_prev  = 1'b0;
    logic [11:0] prev_word  = 12'h0;

    always @(negedge cs_s) begin
        dec_edges = 0;
        dec_word  = 16'h0;
    end

    always @(posedge sclk_s) begin
        if (!cs_s) begin
            dec_word = {dec_word[14:0], sdi_s};
            dec_edges++;
        end
    end

    always @(posedge cs_s) begin
        if (rst_s) begin
            check_eq("sclk_edges", dec_edges, 16);
            check_eq("frame_queued", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check_eq("frame", 32'(dec_word), 32'(exp_q.pop_front()));
            if (inc_mode && have_prev) check_eq("inc_order", 32'(dec_word[11:0]), 32'(prev_word + 12'd1));
            prev_word = dec_word[11:0];
            have_prev = 1'b1;
            dec_frames++;
        end
    end

    task automatic do_reset(input bit which);
        @(posedge sys_clk);
        #3;
        rst0 = 1'b0;
        rst1 = 1'b0;
        sel  = which;
        repeat (3) @(posedge sys_clk);
        #2;
        if (which) rst1 = 1'b1;
        else rst0 = 1'b1;
    endtask

    // mode 0: hold din, 1: new random din every cycle, 2: increment din after each capture
    task automatic run(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            #1;
            if (mode == 1) din = 12'($urandom);
            else if (mode == 2 && m_took) begin
                din    = din + 12'd1;
                m_took = 1'b0;
            end
        end
    endtask

    initial begin
        int f0;
        // default rate: fixed, boundary and per-cycle-toggling samples
        din = 12'hABC;
        do_reset(1'b0);
        f0 = dec_frames;
        run(150, 0);
        din = 12'h000;
        run(100, 0);
        din = 12'hFFF;
        run(100, 0);
        run(200, 1);
        run(100, 0);
        check_eq("p1_frames", dec_frames - f0, 5);

        // asynchronous reset in the middle of bit 7
        din = 12'h5A5;
        do_reset(1'b0);
        repeat (131) @(negedge sys_clk);
        @(posedge sys_clk);
        #3;
        check_eq("pre_rst_cs", 32'(cs0), 32'd0);
        rst0 = 1'b0;
        #1;
        check_eq("async_rst", 32'({cs0, sclk0, sdi0, ld0, busy0, st0, ov0}), 32'(7'b1001000));
        repeat (3) @(posedge sys_clk);
        #2;
        rst0 = 1'b1;
        f0 = dec_frames;
        run(99 + FCYC + 20, 0);
        check_eq("p2_frames", dec_frames - f0, 1);

        // 100 ticks with incrementing samples
        din = 12'($urandom);
        do_reset(1'b0);
        m_took    = 1'b0;
        inc_mode  = 1'b1;
        have_prev = 1'b0;
        f0 = dec_frames;
        run(10080, 2);
        inc_mode = 1'b0;
        check_eq("p3_frames", dec_frames - f0, 100);
        check_eq("p3_no_ovr", 32'(ov0), 32'd0);

        // sample rate faster than a frame
        do_reset(1'b1);
        f0 = dec_frames;
        run(515, 1);
        check_eq("p4_frames", dec_frames - f0, 6);
        check_eq("ovr_sticky", 32'(ov1), 32'd1);
        check_eq("q_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
